sdram_init_cfg: RTL and testbench

Parametrised SDRAM power-up initialisation sequencer. It waits a configurable power-up delay, then issues PRECHARGE-ALL, a configurable number of AUTO-REFRESH commands and a LOAD-MODE-REGISTER command, with the tRP, tRFC and tMRD gaps set by parameters. It then raises `flag_init_end`. It sits between the SDRAM top-level arbiter and the command/address pads, in the same slot as the fixed-timing init block it replaces. It adds on-demand re-initialisation.

---
 rtl/sdram_init_cfg.sv | 153 +++++++++++++++
 tb/tb_sdram_init_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_init_cfg.sv
// rtl/sdram_init_cfg.sv - SDRAM power-up init sequencer with on-demand re-init
// Issues PRE, AREF x AREF_NUM and MSET with parametrised gaps, then holds flag_init_end.
module sdram_init_cfg #(
  parameter int         DELAY_CYC = 20000,
  parameter int         T_RP      = 2,
  parameter int         T_RFC     = 8,
  parameter int         AREF_NUM  = 2,
  parameter int         T_MRD     = 2,
  parameter int         ADDR_W    = 13,
  parameter logic [2:0] MR_BL     = 3'b010,
  parameter logic       MR_BT     = 1'b0,
  parameter logic [2:0] MR_CL     = 3'b011,
  parameter logic       MR_WB     = 1'b0
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              init_req,
  output logic [3:0]        cmd_reg,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [1:0]        sdram_ba,
  output logic              flag_init_end
);

  localparam int MAX_A = (DELAY_CYC > T_RFC) ? DELAY_CYC : T_RFC;
  localparam int MAX_B = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);

  // Gap waits end one cycle early: the command state itself fills the first cycle.
  localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] TRP_END  = CNT_W'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [CNT_W-1:0] TRFC_END = CNT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CNT_W-1:0] TMRD_END = CNT_W'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [3:0]       AREF_N   = 4'(AREF_NUM);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MSET = 4'b0000;

  localparam logic [ADDR_W-1:0] ADDR_PALL = ADDR_W'(11'h400);
  localparam logic [ADDR_W-1:0] ADDR_MODE =
    ADDR_W'({MR_WB, 2'b00, MR_CL, MR_BT, MR_BL});

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_AREF, S_TRFC, S_MRS, S_TMRD, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       ref_q, ref_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ref_d   = ref_q;
    cmd_d   = CMD_NOP;
    done_d  = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (cnt_q == WAIT_END) begin
          state_d = S_PRE;
          cmd_d   = CMD_PRE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRE: begin
        if (T_RP == 1) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
          ref_d   = ref_q + 4'd1;
        end else begin
          state_d = S_TRP;
        end
      end
      S_TRP: begin
        if (cnt_q == TRP_END) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
          ref_d   = ref_q + 4'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_AREF, S_TRFC: begin
        // ref_q already counts the AREF just issued.
        if (state_q == S_AREF && T_RFC != 1) begin
          state_d = S_TRFC;
        end else if (state_q == S_TRFC && cnt_q != TRFC_END) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (ref_q < AREF_N) begin
          state_d = S_AREF;
          cmd_d   = CMD_AREF;
          ref_d   = ref_q + 4'd1;
        end else begin
          state_d = S_MRS;
          cmd_d   = CMD_MSET;
        end
      end
      S_MRS: begin
        if (T_MRD == 1) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_TMRD;
        end
      end
      S_TMRD: begin
        if (cnt_q == TMRD_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Re-init skips the power-up wait and starts straight at PRECHARGE.
        if (init_req) begin
          state_d = S_PRE;
          cmd_d   = CMD_PRE;
          ref_d   = 4'd0;
        end else begin
          done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sclk or posedge s_rst) begin
    if (s_rst) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      ref_q   <= 4'd0;
      cmd_q   <= CMD_NOP;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      done_q  <= done_d;
    end
  end

  assign cmd_reg       = cmd_q;
  assign flag_init_end = done_q;
  assign sdram_ba      = 2'b00;
  assign sdram_addr    = (cmd_q == CMD_MSET) ? ADDR_MODE : ADDR_PALL;

endmodule

// File: tb/tb_sdram_init_cfg.sv
// tb/tb_sdram_init_cfg.sv - self-checking bench for sdram_init_cfg
// Three instances (defaults, back-to-back timing, custom mode word) against a schedule model.
module tb_sdram_init_cfg;

  localparam int NOP  = 4'b0111;
  localparam int PRE  = 4'b0010;
  localparam int AREF = 4'b0001;
  localparam int MSET = 4'b0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic req_a, req_b, req_c;
  logic [3:0]  cmd_a, cmd_b, cmd_c;
  logic [12:0] addr_a, addr_b;
  logic [11:0] addr_c;
  logic [1:0]  ba_a, ba_b, ba_c;
  logic        flag_a, flag_b, flag_c;

  int errors = 0;
  int checks = 0;
  int n_a = 0, b_a = 20000;
  int n_b = 0, b_b = 5;
  int n_c = 0, b_c = 3;
  bit a_done = 1'b0;

  sdram_init_cfg dut_a (
    .sclk(clk), .s_rst(rst_a), .init_req(req_a), .cmd_reg(cmd_a),
    .sdram_addr(addr_a), .sdram_ba(ba_a), .flag_init_end(flag_a)
  );

  sdram_init_cfg #(.DELAY_CYC(5), .T_RP(1), .T_RFC(1), .AREF_NUM(4), .T_MRD(1)) dut_b (
    .sclk(clk), .s_rst(rst_b), .init_req(req_b), .cmd_reg(cmd_b),
    .sdram_addr(addr_b), .sdram_ba(ba_b), .flag_init_end(flag_b)
  );

  sdram_init_cfg #(.DELAY_CYC(3), .T_RP(3), .T_RFC(2), .AREF_NUM(3), .T_MRD(2), .ADDR_W(12),
                   .MR_BL(3'b011), .MR_BT(1'b1), .MR_CL(3'b010), .MR_WB(1'b1)) dut_c (
    .sclk(clk), .s_rst(rst_c), .init_req(req_c), .cmd_reg(cmd_c),
    .sdram_addr(addr_c), .sdram_ba(ba_c), .flag_init_end(flag_c)
  );

  task automatic chk(input string nm, input int cyc, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    end
  endtask

  // Expected command/flag at cycle n when the current pass's PRE is at cycle b.
  task automatic exp_at(input int n, input int b, input int rp, input int rfc, input int an,
                        input int mrd, output int c, output int f);
    int off, m0;
    off = n - b;
    m0  = rp + an * rfc;
    c   = NOP;
    f   = 0;
    if (off == 0) c = PRE;
    else if (off >= rp && off < m0 && (off - rp) % rfc == 0) c = AREF;
    else if (off == m0) c = MSET;
    else if (off >= m0 + mrd) f = 1;
  endtask

  task automatic model_step(input logic rst, input logic req, input int d, input int rp,
                            input int rfc, input int an, input int mrd, inout int n, inout int b);
    int c, f;
    if (rst) begin
      n = 0;
      b = d;
    end else begin
      exp_at(n, b, rp, rfc, an, mrd, c, f);
      n++;
      if (f == 1 && req) b = n;
    end
  endtask

  task automatic check_inst(input string nm, input int n, input int b, input int rp, input int rfc,
                            input int an, input int mrd, input int mw, input int cmd,
                            input int addr, input int flag, input int ba);
    int c, f;
    exp_at(n, b, rp, rfc, an, mrd, c, f);
    chk({nm, " cmd"}, n, cmd, c);
    chk({nm, " addr"}, n, addr, (c == MSET) ? mw : 32'h400);
    chk({nm, " flag"}, n, flag, f);
    chk({nm, " ba"}, n, ba, 0);
  endtask

  function automatic int mode_word(input int bl, input int bt, input int cl, input int wb);
    return (wb << 9) | (cl << 4) | (bt << 3) | bl;
  endfunction

  // Model update on the sampling edge, comparison on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step(rst_a, req_a, 20000, 2, 8, 2, 2, n_a, b_a);
      model_step(rst_b, req_b, 5, 1, 1, 4, 1, n_b, b_b);
      model_step(rst_c, req_c, 3, 3, 2, 3, 2, n_c, b_c);
      @(negedge clk);
      check_inst("a", n_a, b_a, 2, 8, 2, 2, mode_word(2, 0, 3, 0),
                 int'(cmd_a), int'(addr_a), int'(flag_a), int'(ba_a));
      check_inst("b", n_b, b_b, 1, 1, 4, 1, mode_word(2, 0, 3, 0),
                 int'(cmd_b), int'(addr_b), int'(flag_b), int'(ba_b));
      check_inst("c", n_c, b_c, 3, 2, 3, 2, mode_word(3, 1, 2, 1),
                 int'(cmd_c), int'(addr_c), int'(flag_c), int'(ba_c));
    end
  end

  task automatic wait_a(input int t);
    int guard;
    guard = 0;
    while (n_a != t && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    if (n_a != t) begin
      $display("FAIL wait_a timeout: reached %0d expected %0d", n_a, t);
      errors++;
      $fatal(1, "wait bound expired");
    end
  endtask

  // Instance a: directed schedule with literal expectations.
  initial begin
    int c, f;
    rst_a = 1'b1;
    req_a = 1'b0;
    exp_at(20010, 20000, 2, 8, 2, 2, c, f);
    chk("model aref2", 20010, c, AREF);
    exp_at(20018, 20000, 2, 8, 2, 2, c, f);
    chk("model mset", 20018, c, MSET);
    exp_at(20020, 20000, 2, 8, 2, 2, c, f);
    chk("model done", 20020, f, 1);
    exp_at(11, 5, 1, 1, 4, 1, c, f);
    chk("model b done", 11, f, 1);
    chk("model c mode", 0, mode_word(3, 1, 2, 1), 32'h22B);
    repeat (3) @(negedge clk);
    chk("a reset cmd", 0, int'(cmd_a), NOP);
    chk("a reset addr", 0, int'(addr_a), 32'h400);
    chk("a reset flag", 0, int'(flag_a), 0);
    #2 rst_a = 1'b0;
    wait_a(20000); chk("a pre", n_a, int'(cmd_a), PRE);
    wait_a(20002); chk("a aref0", n_a, int'(cmd_a), AREF);
    wait_a(20010); chk("a aref1", n_a, int'(cmd_a), AREF);
    wait_a(20013); #2 req_a = 1'b1;
    wait_a(20014); #2 req_a = 1'b0;
    wait_a(20018); chk("a mset", n_a, int'(cmd_a), MSET);
    chk("a mode addr", n_a, int'(addr_a), 32'h0032);
    wait_a(20019); chk("a flag low", n_a, int'(flag_a), 0);
    wait_a(20020); chk("a flag rise", n_a, int'(flag_a), 1);
    wait_a(20029); #2 req_a = 1'b1;
    wait_a(20030); chk("a reinit pre", n_a, int'(cmd_a), PRE);
    chk("a reinit flag", n_a, int'(flag_a), 0);
    #2 req_a = 1'b0;
    wait_a(20032); chk("a reinit aref0", n_a, int'(cmd_a), AREF);
    wait_a(20040); chk("a reinit aref1", n_a, int'(cmd_a), AREF);
    wait_a(20048); chk("a reinit mset", n_a, int'(cmd_a), MSET);
    wait_a(20050); chk("a reinit done", n_a, int'(flag_a), 1);
    wait_a(20060); chk("a done hold", n_a, int'(flag_a), 1);
    #2 rst_a = 1'b1;
    @(negedge clk);
    #2 rst_a = 1'b0;
    wait_a(20005);
    #2 rst_a = 1'b1;
    #1;
    chk("a async cmd", 20005, int'(cmd_a), NOP);
    chk("a async addr", 20005, int'(addr_a), 32'h400);
    chk("a async flag", 20005, int'(flag_a), 0);
    repeat (3) @(negedge clk);
    #2 rst_a = 1'b0;
    wait_a(19999); chk("a restart nop", n_a, int'(cmd_a), NOP);
    wait_a(20000); chk("a restart pre", n_a, int'(cmd_a), PRE);
    wait_a(20021);
    a_done = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Instances b/c: literal first pass, then random requests, bursts of held requests and resets.
  initial begin
    int rcnt, cyc, ec;
    rst_b = 1'b1; rst_c = 1'b1;
    req_b = 1'b0; req_c = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      case (i)
        5:          ec = PRE;
        6, 7, 8, 9: ec = AREF;
        10:         ec = MSET;
        default:    ec = NOP;
      endcase
      chk("b literal cmd", i, int'(cmd_b), ec);
      chk("b literal flag", i, int'(flag_b), (i >= 11) ? 1 : 0);
      if (i == 12) chk("c literal mode", i, int'(addr_c), 32'h22B);
    end
    rcnt = 0;
    cyc = 0;
    while (!a_done && cyc < 90000) begin
      @(negedge clk);
      #2;
      cyc++;
      if ((cyc / 500) % 3 == 0) begin
        req_b = 1'b1;
        req_c = 1'b1;
      end else begin
        req_b = ($urandom_range(0, 3) == 0);
        req_c = ($urandom_range(0, 3) == 0);
      end
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          rst_b = 1'b0;
          rst_c = 1'b0;
        end
      end else if ($urandom_range(0, 599) == 0) begin
        rcnt = $urandom_range(1, 3);
        rst_b = $urandom_range(0, 1) == 1;
        rst_c = !rst_b;
      end
    end
  end

endmodule
